// File: rtl/twos_to_signmag_32bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | twos_to_signmag_32bit: chunked two's complement to sign-magnitude decode |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module twos_to_signmag_32bit #(
  parameter int CHUNK_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [31:0] out_mag,
  output logic        out_ovf,
  output logic        out_zero
);

  localparam int N   = 32 / CHUNK_W;
  localparam int K_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [31:0]        op_q;
  logic               neg_q;
  logic               carry_q, carry_d;
  logic [K_W-1:0]     k_q;
  logic [31:0]        mag_q, mag_d;
  logic               ovf_q;
  logic               zero_q;

  logic [CHUNK_W-1:0] chunk;
  logic [CHUNK_W:0]   sum;
  logic [CHUNK_W-1:0] res;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid && in_ready) state_d = S_CONV;
      S_CONV:  if (k_q == K_LAST)        state_d = S_HOLD;
      S_HOLD:  if (out_ready)            state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) && !reset;
    out_valid = (state_q == S_HOLD);
    out_sign  = neg_q;
    out_mag   = mag_q;
    out_ovf   = ovf_q;
    out_zero  = zero_q;
  end

  // One chunk of ~op + 1 per cycle; the carry ripples through carry_q.
  always_comb begin
    chunk   = op_q[k_q*CHUNK_W +: CHUNK_W];
    sum     = {1'b0, ~chunk} + {{CHUNK_W{1'b0}}, carry_q};
    res     = neg_q ? sum[CHUNK_W-1:0] : chunk;
    carry_d = neg_q ? sum[CHUNK_W] : carry_q;
    mag_d   = mag_q;
    mag_d[k_q*CHUNK_W +: CHUNK_W] = res;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      k_q     <= '0;
      mag_q   <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            op_q    <= in_data;
            neg_q   <= in_signed & in_data[31];
            carry_q <= 1'b1;
            k_q     <= '0;
            mag_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
          end
        end
        S_CONV: begin
          mag_q   <= mag_d;
          carry_q <= carry_d;
          k_q     <= k_q + K_W'(1);
          if (k_q == K_LAST) begin
            zero_q <= (mag_d == 32'd0);
            ovf_q  <= neg_q && (op_q == 32'h8000_0000);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
